// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use/branch hazard control.
// One cycle D->E; a load-use hazard stalls F/D and bubbles E, and a taken branch flushes D and bubbles E.
module id_ex_stage #(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 5,
  parameter int C_WIDTH = 11
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid_d,
  input  logic [C_WIDTH-1:0] ctrl_d,
  input  logic [D_WIDTH-1:0] rd1_d,
  input  logic [D_WIDTH-1:0] rd2_d,
  input  logic [A_WIDTH-1:0] rs1_d,
  input  logic [A_WIDTH-1:0] rs2_d,
  input  logic [A_WIDTH-1:0] rd_d,
  input  logic [D_WIDTH-1:0] imm_d,
  input  logic [D_WIDTH-1:0] pc_d,
  input  logic               regwrite_m,
  input  logic [A_WIDTH-1:0] rd_m,
  input  logic [D_WIDTH-1:0] alu_result_m,
  input  logic               regwrite_w,
  input  logic [A_WIDTH-1:0] rd_w,
  input  logic [D_WIDTH-1:0] result_w,
  input  logic               pcsrc_e,
  output logic               valid_e,
  output logic [C_WIDTH-1:0] ctrl_e,
  output logic [A_WIDTH-1:0] rs1_e,
  output logic [A_WIDTH-1:0] rs2_e,
  output logic [A_WIDTH-1:0] rd_e,
  output logic [D_WIDTH-1:0] imm_e,
  output logic [D_WIDTH-1:0] pc_e,
  output logic [D_WIDTH-1:0] srca_e,
  output logic [D_WIDTH-1:0] writedata_e,
  output logic [1:0]         fwd_a_e,
  output logic [1:0]         fwd_b_e,
  output logic               stall_f,
  output logic               stall_d,
  output logic               flush_d
);

  localparam int MEMREAD_BIT = 9;

  logic [D_WIDTH-1:0] rd1_e;
  logic [D_WIDTH-1:0] rd2_e;
  logic               load_use;
  logic               bubble;

  assign load_use = valid_e & ctrl_e[MEMREAD_BIT] & (rd_e != '0) & valid_d
                  & ((rd_e == rs1_d) | (rd_e == rs2_d));
  assign bubble   = pcsrc_e | load_use;

  // A taken branch throws away the Decode instruction, so it never needs to stall.
  assign stall_f = load_use & ~pcsrc_e;
  assign stall_d = load_use & ~pcsrc_e;
  assign flush_d = pcsrc_e;

  always_ff @(posedge clk) begin
    if (!rst_n || bubble) begin
      valid_e <= 1'b0;
      ctrl_e  <= '0;
      rs1_e   <= '0;
      rs2_e   <= '0;
      rd_e    <= '0;
      imm_e   <= '0;
      pc_e    <= '0;
      rd1_e   <= '0;
      rd2_e   <= '0;
    end else begin
      valid_e <= valid_d;
      ctrl_e  <= valid_d ? ctrl_d : '0;
      rs1_e   <= rs1_d;
      rs2_e   <= rs2_d;
      rd_e    <= rd_d;
      imm_e   <= imm_d;
      pc_e    <= pc_d;
      rd1_e   <= rd1_d;
      rd2_e   <= rd2_d;
    end
  end

  // Memory stage is checked first: it holds the younger write to the same register.
  always_comb begin
    srca_e  = rd1_e;
    fwd_a_e = 2'b00;
    if (regwrite_m && (rd_m != '0) && (rd_m == rs1_e)) begin
      srca_e  = alu_result_m;
      fwd_a_e = 2'b10;
    end else if (regwrite_w && (rd_w != '0) && (rd_w == rs1_e)) begin
      srca_e  = result_w;
      fwd_a_e = 2'b01;
    end
  end

  always_comb begin
    writedata_e = rd2_e;
    fwd_b_e     = 2'b00;
    if (regwrite_m && (rd_m != '0) && (rd_m == rs2_e)) begin
      writedata_e = alu_result_m;
      fwd_b_e     = 2'b10;
    end else if (regwrite_w && (rd_w != '0) && (rd_w == rs2_e)) begin
      writedata_e = result_w;
      fwd_b_e     = 2'b01;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed hazard scenarios plus random traffic against a pipeline-register model.
module tb_id_ex_stage;

  logic        clk;
  logic        rst_n;
  logic        valid_d;
  logic [10:0] ctrl_d;
  logic [31:0] rd1_d, rd2_d, imm_d, pc_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic        regwrite_m, regwrite_w, pcsrc_e;
  logic [4:0]  rd_m, rd_w;
  logic [31:0] alu_result_m, result_w;
  logic        valid_e;
  logic [10:0] ctrl_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic [31:0] imm_e, pc_e, srca_e, writedata_e;
  logic [1:0]  fwd_a_e, fwd_b_e;
  logic        stall_f, stall_d, flush_d;

  int n_checks = 0;
  int n_fail   = 0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .ctrl_d(ctrl_d),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .imm_d(imm_d), .pc_d(pc_d),
    .regwrite_m(regwrite_m), .rd_m(rd_m), .alu_result_m(alu_result_m),
    .regwrite_w(regwrite_w), .rd_w(rd_w), .result_w(result_w),
    .pcsrc_e(pcsrc_e),
    .valid_e(valid_e), .ctrl_e(ctrl_e), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
    .imm_e(imm_e), .pc_e(pc_e), .srca_e(srca_e), .writedata_e(writedata_e),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference view of the instruction sitting in Execute.
  typedef struct packed {
    logic        v;
    logic [10:0] c;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm, pc, r1, r2;
  } est_t;

  est_t m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_load_use();
    return m.v && m.c[9] && (m.rd != 0) && valid_d && ((m.rd == rs1_d) || (m.rd == rs2_d));
  endfunction

  // Operand value and source tag: youngest in-flight writer of that register wins.
  function automatic logic [33:0] operand(input logic [4:0] idx, input logic [31:0] regval);
    if (idx != 0 && regwrite_m && rd_m == idx) return {2'b10, alu_result_m};
    if (idx != 0 && regwrite_w && rd_w == idx) return {2'b01, result_w};
    return {2'b00, regval};
  endfunction

  task automatic compare_all();
    logic [33:0] a, b;
    logic        lu;
    a  = operand(m.rs1, m.r1);
    b  = operand(m.rs2, m.r2);
    lu = exp_load_use();
    check("valid_e", 32'(valid_e), 32'(m.v));
    check("ctrl_e", 32'(ctrl_e), 32'(m.c));
    check("rs1_e", 32'(rs1_e), 32'(m.rs1));
    check("rs2_e", 32'(rs2_e), 32'(m.rs2));
    check("rd_e", 32'(rd_e), 32'(m.rd));
    check("imm_e", imm_e, m.imm);
    check("pc_e", pc_e, m.pc);
    check("srca_e", srca_e, a[31:0]);
    check("fwd_a_e", 32'(fwd_a_e), 32'(a[33:32]));
    check("writedata_e", writedata_e, b[31:0]);
    check("fwd_b_e", 32'(fwd_b_e), 32'(b[33:32]));
    check("stall_f", 32'(stall_f), 32'(lu && !pcsrc_e));
    check("stall_d", 32'(stall_d), 32'(lu && !pcsrc_e));
    check("flush_d", 32'(flush_d), 32'(pcsrc_e));
  endtask

  task automatic update_model(input logic rst_seen, input logic squash, input est_t nxt);
    if (!rst_seen || squash) m = '0;
    else m = nxt;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    logic rst_seen, squash;
    est_t nxt;
    #1 compare_all();
    rst_seen = rst_n;
    squash   = pcsrc_e || exp_load_use();
    nxt = '{v: valid_d, c: (valid_d ? ctrl_d : 11'h0), rs1: rs1_d, rs2: rs2_d, rd: rd_d,
            imm: imm_d, pc: pc_d, r1: rd1_d, r2: rd2_d};
    @(posedge clk);
    #1 update_model(rst_seen, squash, nxt);
    @(negedge clk);
  endtask

  task automatic idle();
    rst_n = 1'b1; valid_d = 1'b0; ctrl_d = '0;
    rd1_d = '0; rd2_d = '0; rs1_d = '0; rs2_d = '0; rd_d = '0; imm_d = '0; pc_d = '0;
    regwrite_m = 1'b0; rd_m = '0; alu_result_m = '0;
    regwrite_w = 1'b0; rd_w = '0; result_w = '0; pcsrc_e = 1'b0;
  endtask

  initial begin
    idle();
    rst_n = 1'b0; valid_d = 1'b1; ctrl_d = 11'h7FF;
    @(posedge clk);
    @(negedge clk);
    m = '0;
    cycle();
    cycle();
    check("rst_valid_e", 32'(valid_e), 32'h0);
    check("rst_ctrl_e", 32'(ctrl_e), 32'h0);
    check("rst_srca_e", srca_e, 32'h0);
    check("rst_stall_f", 32'(stall_f), 32'h0);
    check("rst_flush_d", 32'(flush_d), 32'h0);

    rst_n = 1'b1; pc_d = 32'h100; imm_d = 32'hFFFF_FFF0;
    cycle();
    check("rel_valid_e", 32'(valid_e), 32'h1);
    check("rel_ctrl_e", 32'(ctrl_e), 32'h7FF);
    check("rel_pc_e", pc_e, 32'h100);

    // M beats W on the same register, then W alone.
    idle(); valid_d = 1'b1; rs1_d = 5'd5; rd1_d = 32'h11;
    cycle();
    idle();
    regwrite_m = 1'b1; rd_m = 5'd5; alu_result_m = 32'hDEADBEEF;
    regwrite_w = 1'b1; rd_w = 5'd5; result_w = 32'h22;
    #1 check("mw_srca", srca_e, 32'hDEADBEEF);
    check("mw_fwd_a", 32'(fwd_a_e), 32'h2);
    regwrite_m = 1'b0;
    #1 check("w_srca", srca_e, 32'h22);
    check("w_fwd_a", 32'(fwd_a_e), 32'h1);
    cycle();

    // x0 is never forwarded.
    idle(); regwrite_m = 1'b1; rd_m = 5'd0; alu_result_m = 32'h55;
    #1 check("x0_wd", writedata_e, 32'h0);
    check("x0_fwd_b", 32'(fwd_b_e), 32'h0);
    cycle();

    // Load-use: lw x7 followed by add using x7.
    idle(); valid_d = 1'b1; ctrl_d = 11'h600; rd_d = 5'd7;
    cycle();
    idle(); valid_d = 1'b1; ctrl_d = 11'h400; rs2_d = 5'd7; rd_d = 5'd8; rd2_d = 32'h1234;
    #1 check("lu_stall_f", 32'(stall_f), 32'h1);
    check("lu_stall_d", 32'(stall_d), 32'h1);
    cycle();
    #1 check("lu_bubble_v", 32'(valid_e), 32'h0);
    check("lu_release", 32'(stall_d), 32'h0);
    cycle();
    idle(); regwrite_w = 1'b1; rd_w = 5'd7; result_w = 32'h99;
    #1 check("lu_wd", writedata_e, 32'h99);
    check("lu_fwd_b", 32'(fwd_b_e), 32'h1);
    cycle();

    // Taken branch flushes Decode and bubbles Execute.
    idle(); valid_d = 1'b1; ctrl_d = 11'h400; pcsrc_e = 1'b1;
    #1 check("br_flush", 32'(flush_d), 32'h1);
    cycle();
    idle();
    #1 check("br_valid_e", 32'(valid_e), 32'h0);
    check("br_ctrl_e", 32'(ctrl_e), 32'h0);
    cycle();

    // Flush takes priority over a simultaneous load-use stall.
    idle(); valid_d = 1'b1; ctrl_d = 11'h600; rd_d = 5'd7;
    cycle();
    idle(); valid_d = 1'b1; ctrl_d = 11'h400; rs1_d = 5'd7; pcsrc_e = 1'b1;
    #1 check("fs_stall_d", 32'(stall_d), 32'h0);
    check("fs_flush_d", 32'(flush_d), 32'h1);
    cycle();
    idle();
    #1 check("fs_valid_e", 32'(valid_e), 32'h0);
    cycle();

    // Reset during a stall clears everything.
    idle(); valid_d = 1'b1; ctrl_d = 11'h600; rd_d = 5'd3; pc_d = 32'h40;
    cycle();
    idle(); valid_d = 1'b1; rs1_d = 5'd3; rst_n = 1'b0;
    cycle();
    idle();
    #1 check("rs_valid_e", 32'(valid_e), 32'h0);
    check("rs_pc_e", pc_e, 32'h0);
    cycle();

    for (int i = 0; i < 600; i++) begin
      rst_n        = ($urandom_range(0, 49) != 0);
      valid_d      = ($urandom_range(0, 3) != 0);
      ctrl_d       = 11'($urandom_range(0, 2047));
      rd1_d        = $urandom;
      rd2_d        = $urandom;
      rs1_d        = 5'($urandom_range(0, 7));
      rs2_d        = 5'($urandom_range(0, 7));
      rd_d         = 5'($urandom_range(0, 7));
      imm_d        = $urandom;
      pc_d         = $urandom;
      regwrite_m   = 1'($urandom_range(0, 1));
      rd_m         = 5'($urandom_range(0, 7));
      alu_result_m = $urandom;
      regwrite_w   = 1'($urandom_range(0, 1));
      rd_w         = 5'($urandom_range(0, 7));
      result_w     = $urandom;
      pcsrc_e      = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
